// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared FSM, load/store encodings and lane helpers for the data-memory controller
package data_mem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE_WR, DONE} state_t;
   localparam logic MEM_READ = 1'b0;
   localparam logic MEM_WRITE = 1'b1;
   localparam logic [2:0] LOAD_SEL_B = 3'd0;
   localparam logic [2:0] LOAD_SEL_H = 3'd1;
   localparam logic [2:0] LOAD_SEL_W = 3'd2;
   localparam logic [2:0] LOAD_SEL_BU = 3'd3;
   localparam logic [2:0] LOAD_SEL_HU = 3'd4;
   localparam logic [1:0] STORE_SEL_B = 2'd0;
   localparam logic [1:0] STORE_SEL_H = 2'd1;
   localparam logic [1:0] STORE_SEL_W = 2'd2;
   function automatic logic is_byte(logic rw, logic [2:0] ls, logic [1:0] ss);
      return rw ? ss == STORE_SEL_B : (ls == LOAD_SEL_B || ls == LOAD_SEL_BU);
   endfunction
   function automatic logic is_half(logic rw, logic [2:0] ls, logic [1:0] ss);
      return rw ? ss == STORE_SEL_H : (ls == LOAD_SEL_H || ls == LOAD_SEL_HU);
   endfunction
   // Lane offset forced to the natural alignment of the access size
   function automatic logic [1:0] lane_off(logic rw, logic [2:0] ls, logic [1:0] ss, logic [1:0] a);
      return is_byte(rw, ls, ss) ? a : is_half(rw, ls, ss) ? {a[1], 1'b0} : 2'b00;
   endfunction
   function automatic logic misaligned_acc(logic rw, logic [2:0] ls, logic [1:0] ss, logic [1:0] a);
      return is_byte(rw, ls, ss) ? 1'b0 : is_half(rw, ls, ss) ? a[0] : |a;
   endfunction
endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// lane_align: little-endian lane extract/extend for loads and sub-word merge for stores
module lane_align
   import data_mem_ctrl_pkg::*;
(
   input  logic [2:0]  load_sel,
   input  logic [1:0]  store_sel,
   input  logic [1:0]  off,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merged
);
   logic [7:0] b;
   logic [15:0] h;
   always_comb begin
      b = rword[{off, 3'b000} +: 8];
      h = off[1] ? rword[31:16] : rword[15:0];
      load_val = load_sel == LOAD_SEL_B  ? {{24{b[7]}}, b} :
                 load_sel == LOAD_SEL_BU ? {24'd0, b} :
                 load_sel == LOAD_SEL_H  ? {{16{h[15]}}, h} :
                 load_sel == LOAD_SEL_HU ? {16'd0, h} : rword;
      merged = rword;
      if (store_sel == STORE_SEL_B)
         merged[{off, 3'b000} +: 8] = wdata[7:0];
      else if (store_sel == STORE_SEL_H)
         merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      else
         merged = wdata;
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle load/store controller for a word-wide SRAM with read-modify-write sub-word stores.
// Define DMEM_MISALIGN_TRAP_EN to suppress and flag misaligned accesses instead of forcing alignment.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   input  logic          mem_rw,
   input  logic [2:0]    load_sel,
   input  logic [1:0]    store_sel,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          busy,
   output logic          done,
   output logic          misaligned,
   output logic          sram_en,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
);
   state_t state;
   logic rw_q;
   logic [2:0] lsel_q;
   logic [1:0] ssel_q, off_q;
   logic [AW-1:0] waddr_q;
   logic [31:0] wdata_q, merged_q, load_val, merged;
   logic accept, mis, go, sw_now;
   assign accept = state == IDLE && req_valid;
`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis = misaligned_acc(mem_rw, load_sel, store_sel, addr[1:0]);
`else
   assign mis = 1'b0;
`endif
   assign go = accept && !mis;
   assign sw_now = mem_rw == MEM_WRITE && store_sel[1];
   // SRAM port is combinational in the accept cycle so read data lands in RD_WAIT
   assign sram_en = go || state == MERGE_WR;
   assign sram_we = (go && sw_now) || state == MERGE_WR;
   assign sram_addr = accept ? addr[AW+1:2] : state == MERGE_WR ? waddr_q : '0;
   assign sram_wdata = state == MERGE_WR ? merged_q : (go && sw_now) ? wdata : '0;
   lane_align u_lane (
      .load_sel(lsel_q),
      .store_sel(ssel_q),
      .off(off_q),
      .rword(sram_rdata),
      .wdata(wdata_q),
      .load_val(load_val),
      .merged(merged)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rw_q <= 1'b0;
         lsel_q <= '0;
         ssel_q <= '0;
         off_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         merged_q <= '0;
         rdata <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               rw_q <= mem_rw;
               lsel_q <= load_sel;
               ssel_q <= store_sel;
               off_q <= lane_off(mem_rw, load_sel, store_sel, addr[1:0]);
               waddr_q <= addr[AW+1:2];
               wdata_q <= wdata;
               busy <= 1'b1;
               done <= mis || sw_now;
               misaligned <= mis;
               state <= (mis || sw_now) ? DONE : RD_WAIT;
            end
            RD_WAIT: begin
               if (rw_q == MEM_READ) rdata <= load_val;
               merged_q <= merged;
               done <= rw_q == MEM_READ;
               state <= rw_q == MEM_READ ? DONE : MERGE_WR;
            end
            MERGE_WR: begin
               done <= 1'b1;
               state <= DONE;
            end
            default: begin
               busy <= 1'b0;
               done <= 1'b0;
               misaligned <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench with a behavioural synchronous SRAM.
// Define DMEM_MISALIGN_TRAP_EN to match a trapping build of the DUT.
module tb_data_mem_ctrl;
   logic clk = 0, rst_n = 0, req_valid = 0, mem_rw = 0;
   logic [2:0] load_sel = 0;
   logic [1:0] store_sel = 0;
   logic [31:0] addr = 0, wdata = 0, rdata, sram_wdata, sram_rdata;
   logic busy, done, misaligned, sram_en, sram_we;
   logic [9:0] sram_addr;
   logic [31:0] mem [0:1023];
   logic [31:0] last_wdata;
   int n_en = 0, n_we = 0, n_done = 0;
   int checks = 0, fails = 0;

   data_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_rw(mem_rw),
      .load_sel(load_sel), .store_sel(store_sel), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .misaligned(misaligned),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_en) begin
         n_en++;
         if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
            last_wdata = sram_wdata;
            n_we++;
         end else
            sram_rdata <= mem[sram_addr];
      end
      if (done) n_done++;
   end

   // Issue one request and wait for done; returns latency, misaligned and rdata from the done cycle
   task automatic access(input logic rw, input logic [2:0] ls, input logic [1:0] ss,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic mo, output logic [31:0] ro);
      @(negedge clk);
      req_valid = 1; mem_rw = rw; load_sel = ls; store_sel = ss; addr = a; wdata = d;
      @(posedge clk); #1;
      req_valid = 0;
      lat = 1;
      while (!done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      mo = misaligned;
      ro = rdata;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (rdata !== 0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
      checks++; if (busy !== 0 || done !== 0 || misaligned !== 0) begin fails++; $display("FAIL reset_flags got %b%b%b want 000", busy, done, misaligned); end
      checks++; if (sram_en !== 0 || sram_we !== 0) begin fails++; $display("FAIL reset_sram_ctl got %b%b want 00", sram_en, sram_we); end
      checks++; if (sram_addr !== 0 || sram_wdata !== 0) begin fails++; $display("FAIL reset_sram_bus got %h/%h want 0/0", sram_addr, sram_wdata); end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_word_roundtrip;
      int lat; logic mo; logic [31:0] ro;
      access(1, 0, 2, 32'h10, 32'hDEADBEEF, lat, mo, ro);
      checks++; if (lat !== 1) begin fails++; $display("FAIL sw_latency got %0d want 1", lat); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem got %h want deadbeef", mem[4]); end
      access(0, 2, 0, 32'h10, 0, lat, mo, ro);
      checks++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got %0d want 2", lat); end
      checks++; if (ro !== 32'hDEADBEEF || mo !== 0) begin fails++; $display("FAIL lw_rdata got %h mis %b want deadbeef mis 0", ro, mo); end
      checks++; if (busy !== 0) begin fails++; $display("FAIL busy_after_done got %b want 0", busy); end
   endtask

   task automatic test_rmw;
      int lat, we0; logic mo; logic [31:0] ro;
      access(1, 0, 2, 32'h10, 32'h11223344, lat, mo, ro);
      we0 = n_we;
      access(1, 0, 0, 32'h12, 32'hFFFFFFAA, lat, mo, ro);
      checks++; if (lat !== 3) begin fails++; $display("FAIL sb_latency got %0d want 3", lat); end
      checks++; if (n_we - we0 !== 1 || last_wdata !== 32'h11AA3344) begin fails++; $display("FAIL sb_write got %0d writes last %h want 1 writes 11aa3344", n_we - we0, last_wdata); end
      checks++; if (mem[4] !== 32'h11AA3344) begin fails++; $display("FAIL sb_mem got %h want 11aa3344", mem[4]); end
      access(1, 0, 1, 32'h12, 32'h0000BEEF, lat, mo, ro);
      checks++; if (lat !== 3 || mem[4] !== 32'hBEEF3344) begin fails++; $display("FAIL sh_mem got %h lat %0d want beef3344 lat 3", mem[4], lat); end
   endtask

   task automatic test_load_ext;
      int lat; logic mo; logic [31:0] ro;
      access(1, 0, 2, 32'h14, 32'h80FF7F01, lat, mo, ro);
      access(0, 0, 0, 32'h17, 0, lat, mo, ro);
      checks++; if (ro !== 32'hFFFFFF80) begin fails++; $display("FAIL lb3 got %h want ffffff80", ro); end
      access(0, 3, 0, 32'h15, 0, lat, mo, ro);
      checks++; if (ro !== 32'h0000007F) begin fails++; $display("FAIL lbu1 got %h want 0000007f", ro); end
      access(0, 1, 0, 32'h16, 0, lat, mo, ro);
      checks++; if (ro !== 32'hFFFF80FF) begin fails++; $display("FAIL lh2 got %h want ffff80ff", ro); end
      access(0, 0, 0, 32'h14, 0, lat, mo, ro);
      checks++; if (ro !== 32'h00000001) begin fails++; $display("FAIL lb0 got %h want 00000001", ro); end
      access(0, 4, 0, 32'h14, 0, lat, mo, ro);
      checks++; if (ro !== 32'h00007F01) begin fails++; $display("FAIL lhu0 got %h want 00007f01", ro); end
      access(0, 7, 0, 32'h14, 0, lat, mo, ro);
      checks++; if (ro !== 32'h80FF7F01) begin fails++; $display("FAIL lsel7_word got %h want 80ff7f01", ro); end
      access(0, 4, 0, 32'h14, 0, lat, mo, ro);
   endtask

   task automatic test_misaligned;
      int lat, en0; logic mo; logic [31:0] ro;
      en0 = n_en;
      access(0, 2, 0, 32'h13, 0, lat, mo, ro);
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++; if (lat !== 1 || mo !== 1) begin fails++; $display("FAIL mis_trap got lat %0d mis %b want 1 1", lat, mo); end
      checks++; if (n_en !== en0 || ro !== 32'h00007F01) begin fails++; $display("FAIL mis_suppress got %0d en rdata %h want 0 en 00007f01", n_en - en0, ro); end
`else
      checks++; if (lat !== 2 || mo !== 0) begin fails++; $display("FAIL mis_align got lat %0d mis %b want 2 0", lat, mo); end
      checks++; if (ro !== 32'hBEEF3344 || n_en - en0 !== 1) begin fails++; $display("FAIL mis_align_data got %h en %0d want beef3344 en 1", ro, n_en - en0); end
`endif
   endtask

   task automatic test_wrap;
      int lat; logic mo; logic [31:0] ro;
      access(1, 0, 2, 32'h1020, 32'h5A5A0000, lat, mo, ro);
      checks++; if (mem[8] !== 32'h5A5A0000) begin fails++; $display("FAIL addr_wrap got %h want 5a5a0000", mem[8]); end
   endtask

   task automatic test_reset_mid;
      int lat, we0; logic mo; logic [31:0] ro;
      access(1, 0, 2, 32'h18, 32'h12345678, lat, mo, ro);
      we0 = n_we;
      @(negedge clk);
      req_valid = 1; mem_rw = 1; store_sel = 1; addr = 32'h18; wdata = 32'h0000ABCD;
      @(posedge clk); #1;
      req_valid = 0;
      checks++; if (busy !== 1) begin fails++; $display("FAIL rmw_busy got %b want 1", busy); end
      rst_n = 0; #1;
      checks++; if ({rdata, busy, done, misaligned, sram_en, sram_we, sram_addr, sram_wdata} !== 0) begin fails++; $display("FAIL mid_reset_outputs got rdata %h flags %b%b%b%b%b addr %h wd %h want all 0", rdata, busy, done, misaligned, sram_en, sram_we, sram_addr, sram_wdata); end
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1;
      repeat (3) @(posedge clk); #1;
      checks++; if (n_we !== we0 || mem[6] !== 32'h12345678) begin fails++; $display("FAIL mid_reset_sram got %0d writes word %h want 0 writes 12345678", n_we - we0, mem[6]); end
      access(0, 2, 0, 32'h18, 0, lat, mo, ro);
      checks++; if (lat !== 2 || ro !== 32'h12345678) begin fails++; $display("FAIL post_reset_lw got %h lat %0d want 12345678 lat 2", ro, lat); end
   endtask

   task automatic test_busy_req;
      int lat, en0, d0; logic mo; logic [31:0] ro;
      access(1, 0, 2, 32'h30, 32'h0, lat, mo, ro);
      en0 = n_en; d0 = n_done;
      @(negedge clk);
      req_valid = 1; mem_rw = 1; store_sel = 0; addr = 32'h20; wdata = 32'h00000055;
      @(negedge clk);
      store_sel = 2; addr = 32'h30; wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 0;
      lat = 0;
      while (!done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      repeat (4) @(posedge clk); #1;
      checks++; if (n_en - en0 !== 2 || n_done - d0 !== 1) begin fails++; $display("FAIL busy_ignore got %0d en %0d done want 2 en 1 done", n_en - en0, n_done - d0); end
      checks++; if (mem[8] !== 32'h5A5A0055 || mem[12] !== 32'h0) begin fails++; $display("FAIL busy_mem got %h/%h want 5a5a0055/00000000", mem[8], mem[12]); end
   endtask

   initial begin
      test_reset;
      test_word_roundtrip;
      test_rmw;
      test_load_ext;
      test_misaligned;
      test_wrap;
      test_reset_mid;
      test_busy_req;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
